uart_secded_tx: RTL and testbench
=================================

UART_SECDED_TX -- requirements
Module: uart_secded_tx

Interface
REQ-001 Parameters SHALL be: DATA_SIZE, default 8, payload width; SIZE_FIFO, default 16, TX FIFO depth (power of 2); SYS_FREQ, default 50000000, clock Hz; BAUD_RATE, default 921600, line rate; SAMPLE, default 32, baud ticks per bit; BAUD_DVSR, default SYS_FREQ/(SAMPLE*BAUD_RATE), clamped to a minimum of 1.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 trans  input  1  write strobe; one FIFO push per clk it is high.
REQ-005 bus_data_in  input  DATA_SIZE  payload sampled when trans=1.
REQ-006 tx  output  1  serial line, idle high.
REQ-007 TX_status_register  output  3  [0] busy (FSM not IDLE), [1] FIFO full, [2] sticky overflow.
REQ-008 baud_en  output  1  one-clk tick every BAUD_DVSR clocks.

Function
REQ-009 Encoder SHALL map d[7:0] to cw[12:0]: cw[3]=d0, cw[5]=d1, cw[6]=d2, cw[7]=d3, cw[9]=d4, cw[10]=d5, cw[11]=d6, cw[12]=d7.
REQ-010 Parity: cw[1]=^{cw3,5,7,9,11}; cw[2]=^{cw3,6,7,10,11}; cw[4]=^{cw5,6,7,12}; cw[8]=^{cw9..12}; cw[0]=^cw[12:1] (even overall).
REQ-011 Frame SHALL be 15 bits: start (0), cw[0] first through cw[12], stop (1); each bit held exactly SAMPLE baud_en ticks.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty (pop and encode that clk); START->DATA after SAMPLE ticks; DATA->STOP after 13th bit; STOP->START if FIFO non-empty, else IDLE.
REQ-013 The tick counter SHALL restart at pop so tx falls the clk after pop and each bit is exactly SAMPLE*BAUD_DVSR clocks.
REQ-014 Back-to-back frames SHALL have no idle gap beyond the single stop bit.
REQ-015 trans while FIFO full SHALL drop the word and set overflow; overflow stays set until reset.
REQ-016 Simultaneous push and pop on a full FIFO SHALL accept the push.
REQ-017 FIFO pointers SHALL wrap modulo SIZE_FIFO; full/empty SHALL use an extra pointer bit.
REQ-018 Encoding SHALL occur at pop; FIFO stores raw payload only.

Reset
REQ-019 reset SHALL force tx=1, state IDLE, FIFO empty, status=3'b000, counters 0, baud_en=0.
REQ-020 reset mid-frame SHALL abort the frame, return tx high the next clk, and discard queued words.

Configuration
REQ-021 With UART_TX_ERR_INJECT_EN defined, input inject_mask[12:0] SHALL be XORed onto cw at pop, for exercising receiver correction/detection.
REQ-022 Without UART_TX_ERR_INJECT_EN, the port SHALL not exist and cw SHALL be sent unmodified.

Structure
REQ-023 A shared package SHALL hold CW_WIDTH=13, FRAME_BITS=15, the FSM state enum and the codeword bit-position constants.
REQ-024 The encoder SHALL be a combinational sub-module secded_encoder, reusable by the receiver's checker.
REQ-025 FIFO, baud divider and FSM SHALL be in uart_secded_tx.

Verification (defaults: BAUD_DVSR=1, 32 clk/bit, 480 clk/frame)
REQ-026 trans 0x00 one clk -> tx low 32 clk, 13x32 clk low, high 32 clk; busy clears on the clk after stop.
REQ-027 trans 0xFF -> serialized cw=13'h1EEE (LSB first) between start and stop.
REQ-028 Four back-to-back trans 0xFF,0x55,0xAB,0xCD -> four contiguous frames in order, 1920 clk total, no gap.
REQ-029 17 pushes while first frame in flight -> 16 accepted, bit[1] set, 17th dropped, bit[2] set and sticky until reset.
REQ-030 reset asserted at clk 200 of a frame -> tx=1 next clk, status 0, no further frames.
REQ-031 With UART_TX_ERR_INJECT_EN, data 0x00 and mask 13'h0008 -> cw bit 3 sent as 1, all others 0.

Source files
------------

// File: rtl/uart_secded_tx_pkg.sv
// Shared definitions for the SECDED UART transmitter and its matching receiver:
// codeword geometry, bit positions inside the Hamming(12,8)+overall-parity
// codeword, and the transmit FSM state type.
package uart_secded_tx_pkg;

  localparam int CW_WIDTH   = 13;  // 8 data + 4 Hamming parity + 1 overall parity
  localparam int FRAME_BITS = 15;  // start + codeword + stop
  localparam int DATA_BITS  = 8;

  // Codeword positions carrying payload bits d[0]..d[7].
  localparam int D_POS [DATA_BITS] = '{3, 5, 6, 7, 9, 10, 11, 12};

  // Codeword positions carrying parity: overall, then Hamming p1, p2, p4, p8.
  localparam int P_POS [5] = '{0, 1, 2, 4, 8};

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/secded_encoder.sv
// Combinational SECDED encoder: places an 8-bit payload into a 13-bit
// extended Hamming codeword (even overall parity in bit 0). Shared with the
// receiver's checker so both ends agree on the bit layout.
module secded_encoder
  import uart_secded_tx_pkg::*;
(
  input  logic [DATA_BITS-1:0] d,
  output logic [CW_WIDTH-1:0]  cw
);

  logic [CW_WIDTH-1:0] c;

  // Scatter payload bits, then derive the four Hamming parities and overall parity.
  always_comb begin
    // NOTE: assigning a default first guarantees every bit is driven on every pass, so no latch is inferred.
    c = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      c[D_POS[i]] = d[i];
    end
    c[P_POS[1]] = ^{c[3], c[5], c[7], c[9], c[11]};
    c[P_POS[2]] = ^{c[3], c[6], c[7], c[10], c[11]};
    c[P_POS[3]] = ^{c[5], c[6], c[7], c[12]};
    c[P_POS[4]] = ^{c[9], c[10], c[11], c[12]};
    c[P_POS[0]] = ^c[CW_WIDTH-1:1];
  end

  assign cw = c;

endmodule

// File: rtl/uart_secded_tx.sv
// UART transmitter with SECDED-protected frames. Raw payload words are queued
// in a FIFO, encoded into a 13-bit codeword at the moment they are popped, and
// sent LSB first between a start and a stop bit, each bit lasting SAMPLE baud
// ticks. Optional feature macro: UART_TX_ERR_INJECT_EN adds an inject_mask
// port whose bits are XORed onto the codeword at pop time.
module uart_secded_tx
  import uart_secded_tx_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int SIZE_FIFO = 16,
  parameter int SYS_FREQ  = 50000000,
  parameter int BAUD_RATE = 921600,
  parameter int SAMPLE    = 32,
  parameter int BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trans,
  input  logic [DATA_SIZE-1:0] bus_data_in,
`ifdef UART_TX_ERR_INJECT_EN
  input  logic [CW_WIDTH-1:0]  inject_mask,
`endif
  output logic                 tx,
  output logic [2:0]           TX_status_register,
  output logic                 baud_en
);

  // A divisor below one (very fast baud against a slow clock) degenerates to
  // a tick every clock.
  localparam int DVSR     = (BAUD_DVSR < 1) ? 1 : BAUD_DVSR;
  localparam int BW       = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int TW       = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
  localparam int AW       = $clog2(SIZE_FIFO);
  localparam int LAST_BIT = FRAME_BITS - 3;  // index of the final codeword bit

  // ---------------------------------------------------------------- FIFO
  logic [DATA_SIZE-1:0] mem [SIZE_FIFO];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full;
  logic                 push, pop;
  logic                 overflow;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same clock frees a slot, so a push on a full FIFO still lands.
  assign push       = trans && (!fifo_full || pop);

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately left out of reset; the pointers alone define what is valid.
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus_data_in;
    end
  end

  // Pointer update and sticky overflow flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (trans && !push) overflow <= 1'b1;
    end
  end

  // ------------------------------------------------------------- encoder
  logic [CW_WIDTH-1:0] cw_enc, cw_tx;

  secded_encoder u_encoder (
    .d  (DATA_BITS'(mem[rd_ptr[AW-1:0]])),
    .cw (cw_enc)
  );

`ifdef UART_TX_ERR_INJECT_EN
  assign cw_tx = cw_enc ^ inject_mask;
`else
  assign cw_tx = cw_enc;
`endif

  // -------------------------------------------------------- baud divider
  tx_state_e       state;
  logic [TW-1:0]   tick_cnt;
  logic            tick_last;
  logic [BW-1:0]   baud_cnt, baud_cnt_nxt;

  assign tick_last = baud_en && (tick_cnt == TW'(SAMPLE - 1));
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && tick_last));

  // The divider phase is realigned on every pop so each bit is exactly
  // SAMPLE*DVSR clocks measured from the clock in which tx falls.
  assign baud_cnt_nxt = (pop || (baud_cnt == BW'(DVSR - 1))) ? '0 : baud_cnt + 1'b1;

  // Divider counter with a registered one-clock tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      baud_en  <= 1'b0;
    end else begin
      baud_cnt <= baud_cnt_nxt;
      baud_en  <= (baud_cnt_nxt == BW'(DVSR - 1));
    end
  end

  // ----------------------------------------------------------------- FSM
  logic [CW_WIDTH-1:0] shift;
  logic [3:0]          bit_cnt;

  // Frame sequencer: start bit, 13 codeword bits LSB first, stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            state    <= START;
            tx       <= 1'b0;
            tick_cnt <= '0;
            shift    <= cw_tx;
          end
        end
        START: begin
          if (tick_last) begin
            state    <= DATA;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift[0];
            shift    <= shift >> 1;
          end else if (baud_en) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_last) begin
            tick_cnt <= '0;
            if (bit_cnt == 4'(LAST_BIT)) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else if (baud_en) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_last) begin
            tick_cnt <= '0;
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
              shift <= cw_tx;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else if (baud_en) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign TX_status_register = {overflow, fifo_full, (state != IDLE)};

endmodule

// File: tb/tb_uart_secded_tx.sv
// Self-checking bench for uart_secded_tx (default parameters: 32 clk/bit,
// 480 clk/frame). Stimulus pushes expected codewords into a scoreboard queue;
// an independent line monitor reconstructs each frame from tx and compares it
// cycle by cycle. Build with UART_TX_ERR_INJECT_EN to cover the inject port.
module tb_uart_secded_tx;
  import uart_secded_tx_pkg::*;

  localparam int BIT_CLKS   = 32;
  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;
`ifdef UART_TX_ERR_INJECT_EN
  localparam logic [CW_WIDTH-1:0] INJ = 13'h0008;
`else
  localparam logic [CW_WIDTH-1:0] INJ = 13'h0000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       trans;
  logic [7:0] bus_data_in;
  logic       tx;
  logic [2:0] TX_status_register;
  logic       baud_en;
`ifdef UART_TX_ERR_INJECT_EN
  logic [CW_WIDTH-1:0] inject_mask = INJ;
`endif

  uart_secded_tx dut (
    .clk                (clk),
    .reset              (reset),
    .trans              (trans),
    .bus_data_in        (bus_data_in),
`ifdef UART_TX_ERR_INJECT_EN
    .inject_mask        (inject_mask),
`endif
    .tx                 (tx),
    .TX_status_register (TX_status_register),
    .baud_en            (baud_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference codeword: payload fills the non-power-of-two positions in
  // order; parity at position 2^k covers every position with bit k set;
  // bit 0 makes the overall parity even.
  function automatic logic [CW_WIDTH-1:0] ref_cw(input logic [7:0] d);
    logic [CW_WIDTH-1:0] c;
    logic                par;
    int                  k;
    c = '0;
    k = 0;
    for (int pos = 1; pos < CW_WIDTH; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p < CW_WIDTH; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos < CW_WIDTH; pos++) begin
        if (pos != p && (pos & p) != 0) par = par ^ c[pos];
      end
      c[p] = par;
    end
    c[0] = ^c[CW_WIDTH-1:1];
    return c ^ INJ;
  endfunction

  // ------------------------------------------------------------ scoreboard
  logic [CW_WIDTH-1:0] sb_q [$];
  int                  mon_start [$];
  int                  mon_frames = 0;
  logic                mon_line [FRAME_CLKS];

  // Line monitor: captures every clock of a frame, aborts on reset.
  initial begin : monitor
    int                    start_cyc;
    int                    bad;
    bit                    aborted;
    logic [FRAME_BITS-1:0] got;
    logic [FRAME_BITS-1:0] ef;
    logic [CW_WIDTH-1:0]   e;
    forever begin
      @(posedge clk);
      #1;
      if (reset === 1'b0 && tx === 1'b0) begin
        start_cyc = cyc;
        aborted   = 1'b0;
        got       = '0;
        for (int k = 0; k < FRAME_CLKS; k++) begin
          if (k > 0) begin
            @(posedge clk);
            #1;
          end
          if (reset === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          mon_line[k] = tx;
          if (k % BIT_CLKS == BIT_CLKS / 2) got[k / BIT_CLKS] = tx;
        end
        if (!aborted) begin
          mon_start.push_back(start_cyc);
          if (sb_q.size() == 0) begin
            check("unexpected_frame", 32'(got), 32'h0);
          end else begin
            e   = sb_q.pop_front();
            ef  = {1'b1, e, 1'b0};
            bad = 0;
            for (int k = 0; k < FRAME_CLKS; k++) begin
              if (mon_line[k] !== ef[k / BIT_CLKS]) bad++;
            end
            check($sformatf("frame%0d_bits", mon_frames), 32'(got), 32'(ef));
            check($sformatf("frame%0d_timing_errs", mon_frames), bad, 0);
          end
          mon_frames++;
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t0;
    t0 = cyc;
    while (mon_frames < n && (cyc - t0) < budget) @(negedge clk);
    check("frames_done", mon_frames, n);
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin : stimulus
    int         a, f, fb, nbase, lows;
    logic [7:0] d;
    logic [7:0] b2b [4];
    b2b[0] = 8'hFF; b2b[1] = 8'h55; b2b[2] = 8'hAB; b2b[3] = 8'hCD;

    reset = 1'b1;
    trans = 1'b0;
    bus_data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_status", TX_status_register, 3'b000);
    check("rst_baud_en", baud_en, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single 0x00 frame with exact edge timing of tx and busy.
    trans = 1'b1; bus_data_in = 8'h00; a = cyc + 1;
    sb_q.push_back(ref_cw(8'h00));
    @(negedge clk);
    trans = 1'b0;
    check("tx_high_before_pop", tx, 1'b1);
    wait_cyc(a + 1);
    check("tx_falls_after_pop", tx, 1'b0);
    check("busy_set", TX_status_register[0], 1'b1);
    wait_cyc(a + FRAME_CLKS);
    check("busy_during_stop", TX_status_register[0], 1'b1);
    wait_cyc(a + FRAME_CLKS + 1);
    check("busy_clears", TX_status_register[0], 1'b0);
    check("tx_idle_high", tx, 1'b1);

    // 0xFF must serialize as the known codeword 0x1EEE.
    @(negedge clk);
    trans = 1'b1; bus_data_in = 8'hFF;
    sb_q.push_back(13'h1EEE ^ INJ);
    @(negedge clk);
    trans = 1'b0;
    wait_frames(2, 2 * FRAME_CLKS);

    // Four back-to-back words: contiguous frames, 1920 clocks in total.
    nbase = mon_start.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      trans = 1'b1; bus_data_in = b2b[i];
      if (i == 0) a = cyc + 1;
      sb_q.push_back((i == 0) ? (13'h1EEE ^ INJ) : ref_cw(b2b[i]));
    end
    @(negedge clk);
    trans = 1'b0;
    wait_frames(6, 5 * FRAME_CLKS);
    if (mon_start.size() >= nbase + 4) begin
      check("b2b_first_start", mon_start[nbase], a + 1);
      for (int i = 1; i < 4; i++)
        check($sformatf("b2b_gap%0d", i), mon_start[nbase + i] - mon_start[nbase + i - 1], FRAME_CLKS);
      check("b2b_total", mon_start[nbase + 3] + FRAME_CLKS - mon_start[nbase], 4 * FRAME_CLKS);
    end

    // Overflow: one word in flight, then 17 pushes into a 16-deep FIFO.
    @(negedge clk);
    d = 8'($urandom);
    trans = 1'b1; bus_data_in = d; a = cyc + 1;
    sb_q.push_back(ref_cw(d));
    @(negedge clk);
    trans = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        check("full_after_16", TX_status_register[1], 1'b1);
        check("no_overflow_yet", TX_status_register[2], 1'b0);
      end
      d = 8'($urandom);
      trans = 1'b1; bus_data_in = d;
      if (i < 16) sb_q.push_back(ref_cw(d));
    end
    @(negedge clk);
    trans = 1'b0;
    check("overflow_set", TX_status_register[2], 1'b1);
    // Push exactly on the clock the next word is popped: must be accepted.
    wait_cyc(a + FRAME_CLKS);
    d = 8'($urandom);
    check("full_before_simul", TX_status_register[1], 1'b1);
    trans = 1'b1; bus_data_in = d;
    sb_q.push_back(ref_cw(d));
    @(negedge clk);
    trans = 1'b0;
    check("full_after_simul", TX_status_register[1], 1'b1);
    wait_frames(24, 19 * FRAME_CLKS);
    check("overflow_sticky", TX_status_register[2], 1'b1);
    check("fifo_drained", TX_status_register[1], 1'b0);

    // Random words at random spacing.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 700)) @(negedge clk);
      @(negedge clk);
      d = 8'($urandom);
      trans = 1'b1; bus_data_in = d;
      sb_q.push_back(ref_cw(d));
      @(negedge clk);
      trans = 1'b0;
    end
    wait_frames(32, 9 * FRAME_CLKS);

    // Reset 200 clocks into a frame with further words queued.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) a = cyc + 1;
      trans = 1'b1; bus_data_in = 8'($urandom);
      @(negedge clk);
    end
    trans = 1'b0;
    f = a + 1;
    wait_cyc(f + 199);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_tx", tx, 1'b1);
    check("midreset_status", TX_status_register, 3'b000);
    check("midreset_baud_en", baud_en, 1'b0);
    reset = 1'b0;
    fb = mon_frames;
    lows = 0;
    repeat (2 * FRAME_CLKS) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_tx_after_reset", lows, 0);
    check("no_frames_after_reset", mon_frames, fb);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
